// File: rtl/aqalu_pkg.sv
// Shared types and constants for the AQALU two-port arbiter.
package aqalu_pkg;

  localparam int OPERAND_W = 2;
  localparam int OPCODE_W  = 4;
  localparam int RESULT_W  = 8;

  // Opcode parked on the ALU when idle; also the no-op command code.
  localparam logic [OPCODE_W-1:0] IDLE_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic [OPCODE_W-1:0]  opcode;
  } cmd_t;

endpackage

// File: rtl/aqalu_rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the caller owns last_grant.
module aqalu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // Pick the port that did not win last time when both ask, else the lone asker.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = |req;
    grant_id    = 1'b0;
    if (req == 2'b11) begin
      grant_id = ~last_grant;
    end else if (req[1]) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/aqalu_arbiter.sv
// Shares one AQALU between two requesters: round-robin grant, fixed-latency
// execute window, per-port valid/ready response, saturating completion count.
module aqalu_arbiter #(
  parameter int         ALU_LATENCY = 2,     // 1..15 EXEC cycles before sampling
  parameter logic [3:0] IDLE_OPCODE = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_a,
  input  logic [1:0]  req0_b,
  input  logic [3:0]  req0_opcode,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [7:0]  rsp0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_a,
  input  logic [1:0]  req1_b,
  input  logic [3:0]  req1_opcode,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [7:0]  rsp1_data,
  output logic [1:0]  alu_a,
  output logic [1:0]  alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [7:0]  alu_result,
  output logic        busy,
  output logic [15:0] op_count
);

  import aqalu_pkg::*;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY);

  state_t     state;
  logic       last_grant;
  logic       gid;
  logic [3:0] cnt;

  logic       grant_valid;
  logic       grant_id;
  cmd_t       sel_cmd;
  logic       accept;
  logic       rsp_done;

  aqalu_rr_arb2 u_arb (
    .req         ({req1_valid, req0_valid}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Command of whichever port currently holds the grant.
  assign sel_cmd = grant_id ? cmd_t'{req1_a, req1_b, req1_opcode}
                            : cmd_t'{req0_a, req0_b, req0_opcode};

  assign req0_ready = (state == ST_IDLE) && grant_valid && !grant_id;
  assign req1_ready = (state == ST_IDLE) && grant_valid &&  grant_id;
  assign accept     = (state == ST_IDLE) && grant_valid;
  assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign busy       = (state != ST_IDLE);

  // Control FSM with registered ALU drive, response and counter outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: async reset clears every register so an in-flight op or pending response is dropped.
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gid        <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= IDLE_OPCODE;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      op_count   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_grant <= grant_id;
            gid        <= grant_id;
            if (sel_cmd.opcode != IDLE_OPCODE) begin
              alu_a      <= sel_cmd.a;
              alu_b      <= sel_cmd.b;
              alu_opcode <= sel_cmd.opcode;
              cnt        <= CNT_INIT;
              state      <= ST_EXEC;
            end else begin
              // No-op: answer with zero without touching the ALU.
              if (grant_id) begin
                rsp1_data  <= '0;
                rsp1_valid <= 1'b1;
              end else begin
                rsp0_data  <= '0;
                rsp0_valid <= 1'b1;
              end
              state <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= IDLE_OPCODE;
            if (gid) begin
              rsp1_data  <= alu_result;
              rsp1_valid <= 1'b1;
            end else begin
              rsp0_data  <= alu_result;
              rsp0_valid <= 1'b1;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (op_count != 16'hFFFF) begin
              op_count <= op_count + 16'd1;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aqalu_arbiter.sv
// Directed bench for aqalu_arbiter with an expected-result scoreboard.
module tb_aqalu_arbiter;

  localparam int ALU_LATENCY = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_opcode = 4'hF, req1_opcode = 4'hF;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [7:0]  rsp0_data, rsp1_data;
  logic [1:0]  alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_result = '0;
  logic        busy;
  logic [15:0] op_count;

  aqalu_arbiter #(.ALU_LATENCY(ALU_LATENCY), .IDLE_OPCODE(4'hF)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_opcode(req0_opcode),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_opcode(req1_opcode),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .busy(busy), .op_count(op_count)
  );

  always #5 clock = ~clock;

  // ALU stub: {opcode, a, b} settles one register after the operands, well
  // inside the ALU_LATENCY-cycle hold window.
  always @(posedge clock) alu_result <= {alu_opcode, alu_a, alu_b};

  typedef struct {
    logic       port;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  logic        grants[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_count = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] a, input logic [1:0] b,
                                       input logic [3:0] op);
    return (op == 4'hF) ? 8'h00 : {op, a, b};
  endfunction

  task automatic check_rsp(input logic port, input logic [7:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_port", 32'(port), 32'(e.port));
      chk("rsp_data", 32'(data), 32'(e.data));
    end
    if (exp_count != 16'hFFFF) exp_count++;
  endtask

  // One clock: record accepts/handshakes due at the coming edge, then advance.
  task automatic tick();
    logic acc0, acc1, hs0, hs1;
    #1;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    hs0  = rsp0_valid && rsp0_ready;
    hs1  = rsp1_valid && rsp1_ready;
    if (acc0) begin
      sb.push_back('{1'b0, model(req0_a, req0_b, req0_opcode)});
      grants.push_back(1'b0);
    end
    if (acc1) begin
      sb.push_back('{1'b1, model(req1_a, req1_b, req1_opcode)});
      grants.push_back(1'b1);
    end
    if (hs0) check_rsp(1'b0, rsp0_data);
    if (hs1) check_rsp(1'b1, rsp1_data);
    @(posedge clock);
    #1;
    if (acc0) req0_valid = 1'b0;
    if (acc1) req1_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req0_valid || req1_valid || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic drive0(input logic [1:0] a, input logic [1:0] b, input logic [3:0] op);
    req0_a = a; req0_b = b; req0_opcode = op; req0_valid = 1'b1;
  endtask

  task automatic drive1(input logic [1:0] a, input logic [1:0] b, input logic [3:0] op);
    req1_a = a; req1_b = b; req1_opcode = op; req1_valid = 1'b1;
  endtask

  initial begin
    int  n;
    // Reset state while reset is held.
    repeat (2) @(negedge clock);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk("rst_rsp_data", 32'({rsp0_data, rsp1_data}), 32'd0);
    chk("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Single op with latency check.
    drive0(2'd2, 2'd1, 4'h3);
    #1 chk("single_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    chk("single_busy", 32'(busy), 32'd1);
    n = 1;
    while (!rsp0_valid && n < 20) begin tick(); n++; end
    chk("single_latency", 32'(n), 32'(ALU_LATENCY + 1));
    chk("single_data_direct", 32'(rsp0_data), 32'h39);
    tick();
    chk("single_valid_drop", 32'(rsp0_valid), 32'd0);
    chk("single_op_count", 32'(op_count), 32'(exp_count));
    chk("single_op_count_abs", 32'(op_count), 32'd1);

    // No-op: response one cycle after the accept edge, ALU never driven.
    drive0(2'd3, 2'd3, 4'hF);
    n = 0;
    while (!rsp0_valid && n < 10) begin
      tick();
      n++;
      chk("noop_alu_idle", 32'(alu_opcode), 32'hF);
    end
    chk("noop_latency", 32'(n), 32'd1);
    drain(10);
    chk("noop_op_count", 32'(op_count), 32'(exp_count));

    // Backpressure on port 1 while port 0 waits.
    rsp1_ready = 1'b0;
    drive1(2'd2, 2'd2, 4'h1);
    n = 0;
    while (!rsp1_valid && n < 10) begin tick(); n++; end
    drive0(2'd0, 2'd3, 4'h6);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("bp_valid_held", 32'(rsp1_valid), 32'd1);
      chk("bp_data_held", 32'(rsp1_data), 32'h1A);
      chk("bp_no_grant", 32'(req0_ready), 32'd0);
      chk("bp_alu_idle", 32'(alu_opcode), 32'hF);
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(rsp1_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_grant0", 32'(req0_ready), 32'd1);
    drain(20);
    chk("bp_op_count", 32'(op_count), 32'(exp_count));

    // Asynchronous reset in the final EXEC cycle.
    drive0(2'd1, 2'd1, 4'h2);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'hF0);
    chk("mid_rst_op_count", 32'(op_count), 32'd0);
    sb.delete();
    grants.delete();
    exp_count = '0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    end

    // Ties from reset alternate 0,1,0,1.
    drive0(2'd3, 2'd2, 4'h9);
    drive1(2'd1, 2'd3, 4'h5);
    drain(30);
    drive0(2'd1, 2'd0, 4'h7);
    drive1(2'd0, 2'd1, 4'hC);
    drain(30);
    chk("tie_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      chk("tie_order", 32'(grants[i]), 32'(i % 2));
    end
    chk("tie_op_count", 32'(op_count), 32'(exp_count));

    // Saturation: preload the counter just below the ceiling.
    force dut.op_count = 16'hFFFE;
    #1;
    release dut.op_count;
    exp_count = 16'hFFFE;
    drive0(2'd1, 2'd2, 4'h4);
    drain(20);
    chk("sat_reach", 32'(op_count), 32'hFFFF);
    drive1(2'd2, 2'd1, 4'h0);
    drain(20);
    chk("sat_hold", 32'(op_count), 32'hFFFF);
    chk("sat_model", 32'(op_count), 32'(exp_count));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
